ireg_mp: RTL

//  Parametrised integer register file for the RISC-V core: NREAD synchronous read ports and

---
 rtl/ireg_mp.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ireg_mp.sv
// ---------------------------------------------------------------------------------------------
// ireg_mp -- multi-ported integer register file for the RISC-V core.
//
// Provides NREAD synchronous read ports and NWRITE write ports. Reads use write-first
// bypassing, x0 is hardwired to zero, and an optional per-register busy scoreboard tracks
// pending writebacks. The block sits between decode (reads, reservations) and writeback
// (writes).
//
// Build option:
//   IREG_SCOREBOARD_EN  When defined, busy bits are stored, rsv_v/rsv_addr set them and
//                       rs_busy reports them. When undefined, there is no busy storage,
//                       rsv_v/rsv_addr are ignored and rs_busy is tied to 0.
//
// Ports:
//   clk       in   clock; all state updates on the rising edge
//   rst_n     in   asynchronous active-low reset
//   rs_addr   in   NREAD*AW     read address per port, sampled every cycle
//   rs_data   out  NREAD*XLEN   read data, 1-cycle latency
//   rs_busy   out  NREAD        addressed register has a pending write (combinational)
//   wr_v      in   NWRITE       write valid per port
//   wr_addr   in   NWRITE*AW    write address per port
//   wr_data   in   NWRITE*XLEN  write data per port
//   rsv_v     in   reserve rsv_addr (set busy) at the end of the cycle
//   rsv_addr  in   AW           register to reserve
// ---------------------------------------------------------------------------------------------
module ireg_mp #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned NREAD  = 2,
   parameter int unsigned NWRITE = 1,
   localparam int unsigned AW    = $clog2(NREG)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NREAD*AW-1:0]           rs_addr,
   output logic signed [NREAD*XLEN-1:0]  rs_data,
   output logic [NREAD-1:0]              rs_busy,
   input  logic [NWRITE-1:0]             wr_v,
   input  logic [NWRITE*AW-1:0]          wr_addr,
   input  logic [NWRITE*XLEN-1:0]        wr_data,
   input  logic                          rsv_v,
   input  logic [AW-1:0]                 rsv_addr
);

   logic [XLEN-1:0] regs_q [NREG];

   logic [AW-1:0]   ra [NREAD];
   logic [AW-1:0]   wa [NWRITE];
   logic [XLEN-1:0] wd [NWRITE];

   always_comb begin
      for (int i = 0; i < NREAD; i++) ra[i] = rs_addr[i*AW +: AW];
      for (int k = 0; k < NWRITE; k++) begin
         wa[k] = wr_addr[k*AW +: AW];
         wd[k] = wr_data[k*XLEN +: XLEN];
      end
   end

   // Array write. Ascending port order means the highest-indexed port wins on a collision.
   // Entry 0 is never written, so it holds zero forever.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      end else begin
         for (int k = 0; k < NWRITE; k++) begin
            if (wr_v[k] && (wa[k] != '0)) regs_q[wa[k]] <= wd[k];
         end
      end
   end

   // Read path: the array is read with the pre-write contents, and a same-cycle write to the
   // sampled address is captured separately so the output mux never re-reads the array.
   logic [XLEN-1:0]  rd_arr_d  [NREAD];
   logic [XLEN-1:0]  rd_arr_q  [NREAD];
   logic [XLEN-1:0]  byp_data_d[NREAD];
   logic [XLEN-1:0]  byp_data_q[NREAD];
   logic [NREAD-1:0] byp_hit_d;
   logic [NREAD-1:0] byp_hit_q;

   always_comb begin
      byp_hit_d = '0;
      for (int i = 0; i < NREAD; i++) begin
         rd_arr_d[i]   = regs_q[ra[i]];
         byp_data_d[i] = '0;
         for (int k = 0; k < NWRITE; k++) begin
            if (wr_v[k] && (wa[k] == ra[i]) && (ra[i] != '0)) begin
               byp_hit_d[i]  = 1'b1;
               byp_data_d[i] = wd[k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp_hit_q <= '0;
         for (int i = 0; i < NREAD; i++) begin
            rd_arr_q[i]   <= '0;
            byp_data_q[i] <= '0;
         end
      end else begin
         byp_hit_q <= byp_hit_d;
         for (int i = 0; i < NREAD; i++) begin
            rd_arr_q[i]   <= rd_arr_d[i];
            byp_data_q[i] <= byp_data_d[i];
         end
      end
   end

   always_comb begin
      rs_data = '0;
      for (int i = 0; i < NREAD; i++) begin
         rs_data[i*XLEN +: XLEN] = byp_hit_q[i] ? byp_data_q[i] : rd_arr_q[i];
      end
   end

`ifdef IREG_SCOREBOARD_EN
   logic [NREG-1:0] busy_q;

   // Writes clear first; the reservation is applied last so a same-cycle reserve wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         for (int k = 0; k < NWRITE; k++) begin
            if (wr_v[k]) busy_q[wa[k]] <= 1'b0;
         end
         if (rsv_v && (rsv_addr != '0)) busy_q[rsv_addr] <= 1'b1;
      end
   end

   // A write landing this cycle bypasses next cycle, so it already counts as ready.
   always_comb begin
      rs_busy = '0;
      for (int i = 0; i < NREAD; i++) begin
         logic wr_hit;
         wr_hit = 1'b0;
         for (int k = 0; k < NWRITE; k++) begin
            if (wr_v[k] && (wa[k] == ra[i])) wr_hit = 1'b1;
         end
         rs_busy[i] = busy_q[ra[i]] & ~wr_hit;
      end
   end
`else
   logic unused_rsv;
   assign unused_rsv = ^{rsv_v, rsv_addr};
   assign rs_busy    = '0;
`endif

endmodule
